// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind round grader.
package mastermind_pkg;

   localparam int NUM_POS    = 4;
   localparam int NUM_SHAPES = 6;
   localparam int SHAPE_W    = 3;
   localparam int MAX_ROUNDS = 8;

   localparam int CNT_W = $clog2(NUM_POS + 1);
   localparam int RND_W = $clog2(MAX_ROUNDS + 1);
   localparam int IDX_W = $clog2(NUM_POS);

   // Codes 0 and 7 are illegal.
   typedef enum logic [SHAPE_W-1:0] {
      T = 3'd1,
      C = 3'd2,
      O = 3'd3,
      D = 3'd4,
      I = 3'd5,
      Z = 3'd6
   } shape_t;

   typedef shape_t [NUM_POS-1:0] pattern_t;

   typedef enum logic [2:0] {
      IDLE,
      READY,
      EXACT,
      COLOR,
      REPORT,
      OVER
   } grader_state_t;

   function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic pattern_legal(input pattern_t p);
      logic                ok;
      logic [SHAPE_W-1:0]  v;
      ok = 1'b1;
      for (int i = 0; i < NUM_POS; i++) begin
         v = p[i];
         if (v == '0 || v > SHAPE_W'(NUM_SHAPES)) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/mastermind_grader_ctrl_shape_counter.sv
// Combinational count of how many pegs of a pattern carry a given shape.
module shape_counter
   import mastermind_pkg::*;
(
   input  pattern_t          pattern,
   input  shape_t            shape,
   output logic [CNT_W-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_POS; i++) begin
         if (pattern[i] == shape) count = count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mastermind_grader_ctrl.sv
// Round-level Mastermind controller: captures master/guess, grades serially,
// counts rounds and declares won/lost.
//
// state  | meaning
// IDLE   | after reset, waiting for start_game
// READY  | game running, waiting for a legal grade_it
// EXACT  | one peg position per cycle, counting exact matches
// COLOR  | one shape per cycle, summing min(guess count, master count)
// REPORT | publish znarly/zood, bump round, decide won/lost
// OVER   | game finished, results held until start_game
module mastermind_grader_ctrl
   import mastermind_pkg::*;
(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start_game,
   input  logic [NUM_POS*SHAPE_W-1:0]  master,
   input  logic                        grade_it,
   input  logic [NUM_POS*SHAPE_W-1:0]  guess,
   output logic                        busy,
   output logic                        grade_valid,
   output logic [CNT_W-1:0]            znarly,
   output logic [CNT_W-1:0]            zood,
   output logic [RND_W-1:0]            round_num,
   output logic                        bad_guess,
   output logic                        won,
   output logic                        lost
);

   grader_state_t       state_q, state_d;
   pattern_t            master_q, guess_q;
   logic [CNT_W-1:0]    exact_acc, total_acc;
   logic [IDX_W-1:0]    idx_q;
   logic [SHAPE_W-1:0]  shape_q;
   logic [CNT_W-1:0]    cnt_guess, cnt_master;
   logic [RND_W-1:0]    round_inc;
   logic                guess_ok, all_exact, last_round;

   shape_counter u_cnt_guess (
      .pattern (guess_q),
      .shape   (shape_t'(shape_q)),
      .count   (cnt_guess)
   );

   shape_counter u_cnt_master (
      .pattern (master_q),
      .shape   (shape_t'(shape_q)),
      .count   (cnt_master)
   );

   assign guess_ok   = pattern_legal(pattern_t'(guess));
   assign all_exact  = (exact_acc == CNT_W'(NUM_POS));
   assign round_inc  = round_num + RND_W'(1);
   assign last_round = (round_inc == RND_W'(MAX_ROUNDS));

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         READY:  if (grade_it && guess_ok) state_d = EXACT;
         EXACT: begin
            busy = 1'b1;
            if (idx_q == IDX_W'(NUM_POS - 1)) state_d = COLOR;
         end
         COLOR: begin
            busy = 1'b1;
            if (shape_q == SHAPE_W'(NUM_SHAPES)) state_d = REPORT;
         end
         REPORT: begin
            busy    = 1'b1;
            state_d = (all_exact || last_round) ? OVER : READY;
         end
         default: ;
      endcase
      // start_game overrides everything, including an in-flight grade
      if (start_game) state_d = READY;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         master_q    <= pattern_t'({NUM_POS*SHAPE_W{1'b0}});
         guess_q     <= pattern_t'({NUM_POS*SHAPE_W{1'b0}});
         exact_acc   <= '0;
         total_acc   <= '0;
         idx_q       <= '0;
         shape_q     <= '0;
         grade_valid <= 1'b0;
         bad_guess   <= 1'b0;
         znarly      <= '0;
         zood        <= '0;
         round_num   <= '0;
         won         <= 1'b0;
         lost        <= 1'b0;
      end else begin
         grade_valid <= 1'b0;
         bad_guess   <= 1'b0;
         if (start_game) begin
            master_q  <= pattern_t'(master);
            round_num <= '0;
            won       <= 1'b0;
            lost      <= 1'b0;
            znarly    <= '0;
            zood      <= '0;
         end else begin
            case (state_q)
               READY: begin
                  if (grade_it) begin
                     if (guess_ok) begin
                        guess_q   <= pattern_t'(guess);
                        exact_acc <= '0;
                        total_acc <= '0;
                        idx_q     <= '0;
                        shape_q   <= SHAPE_W'(1);
                     end else begin
                        bad_guess <= 1'b1;
                     end
                  end
               end
               EXACT: begin
                  if (guess_q[idx_q] == master_q[idx_q]) exact_acc <= exact_acc + CNT_W'(1);
                  idx_q <= idx_q + IDX_W'(1);
               end
               COLOR: begin
                  total_acc <= total_acc + min_cnt(cnt_guess, cnt_master);
                  shape_q   <= shape_q + SHAPE_W'(1);
               end
               REPORT: begin
                  grade_valid <= 1'b1;
                  znarly      <= exact_acc;
                  // total_acc always includes every exact match, so this cannot underflow
                  zood        <= total_acc - exact_acc;
                  round_num   <= round_inc;
                  won         <= all_exact;
                  lost        <= !all_exact && last_round;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mastermind_grader_ctrl.sv
// Self-checking bench for mastermind_grader_ctrl: vector table plus scoreboard.
module tb_mastermind_grader_ctrl;

   localparam logic [2:0] S_T = 3'd1, S_C = 3'd2, S_O = 3'd3, S_D = 3'd4,
                          S_I = 3'd5, S_Z = 3'd6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_game = 1'b0;
   logic [11:0] master = '0;
   logic        grade_it = 1'b0;
   logic [11:0] guess = '0;
   logic        busy, grade_valid, bad_guess, won, lost;
   logic [2:0]  znarly, zood;
   logic [3:0]  round_num;

   mastermind_grader_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .start_game  (start_game),
      .master      (master),
      .grade_it    (grade_it),
      .guess       (guess),
      .busy        (busy),
      .grade_valid (grade_valid),
      .znarly      (znarly),
      .zood        (zood),
      .round_num   (round_num),
      .bad_guess   (bad_guess),
      .won         (won),
      .lost        (lost)
   );

   always #5 clock = ~clock;

   typedef struct {
      int   znarly;
      int   zood;
      int   round;
      logic won;
      logic lost;
      int   cyc;
   } sb_t;

   typedef struct {
      logic [11:0] master;
      logic [11:0] guess;
      int          znarly;
      int          zood;
   } vec_t;

   sb_t  sb[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   exp_round = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [11:0] pat(input logic [2:0] p0, input logic [2:0] p1,
                                       input logic [2:0] p2, input logic [2:0] p3);
      return {p3, p2, p1, p0};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (grade_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grade_valid: got 1 expected 0 (t=%0t)", $time);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("latency_cycle", cyc, e.cyc);
            check("znarly", int'(znarly), e.znarly);
            check("zood", int'(zood), e.zood);
            check("round_num", int'(round_num), e.round);
            check("won", int'(won), int'(e.won));
            check("lost", int'(lost), int'(e.lost));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL grade_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic new_game(input logic [11:0] m);
      start_game = 1'b1;
      master     = m;
      step();
      start_game = 1'b0;
      master     = 12'($urandom);
      exp_round  = 0;
   endtask

   task automatic grade(input logic [11:0] g, input int ez, input int ezo,
                        input logic ew, input logic el);
      sb_t e;
      grade_it = 1'b1;
      guess    = g;
      e.znarly = ez;
      e.zood   = ezo;
      e.round  = exp_round + 1;
      e.won    = ew;
      e.lost   = el;
      e.cyc    = cyc + 12;
      sb.push_back(e);
      exp_round++;
      step();
      grade_it = 1'b0;
      guess    = 12'($urandom);
      check("busy_after_capture", int'(busy), 1);
      wait_drain();
   endtask

   initial begin
      vecs[0] = '{pat(S_T,S_C,S_O,S_D), pat(S_T,S_C,S_O,S_D), 4, 0};
      vecs[1] = '{pat(S_T,S_C,S_O,S_D), pat(S_D,S_O,S_C,S_T), 0, 4};
      vecs[2] = '{pat(S_T,S_C,S_O,S_D), pat(S_T,S_T,S_T,S_T), 1, 0};
      vecs[3] = '{pat(S_T,S_C,S_O,S_D), pat(S_C,S_T,S_Z,S_Z), 0, 2};
      vecs[4] = '{pat(S_T,S_T,S_C,S_C), pat(S_Z,S_Z,S_Z,S_Z), 0, 0};
      vecs[5] = '{pat(S_I,S_I,S_Z,S_O), pat(S_Z,S_I,S_O,S_I), 1, 3};
      vecs[6] = '{pat(S_T,S_C,S_O,S_D), pat(S_T,S_C,S_D,S_O), 2, 2};

      // reset state
      repeat (3) step();
      check("rst_busy", int'(busy), 0);
      check("rst_grade_valid", int'(grade_valid), 0);
      check("rst_znarly", int'(znarly), 0);
      check("rst_zood", int'(zood), 0);
      check("rst_round_num", int'(round_num), 0);
      check("rst_won_lost", int'({won, lost, bad_guess}), 0);
      reset = 1'b0;
      step();

      // grade_it in IDLE is ignored
      grade_it = 1'b1;
      guess    = pat(S_T,S_C,S_O,S_D);
      step();
      grade_it = 1'b0;
      check("idle_ignores_grade", int'(busy), 0);
      repeat (14) step();

      // table-driven single-round games
      foreach (vecs[v]) begin
         new_game(vecs[v].master);
         grade(vecs[v].guess, vecs[v].znarly, vecs[v].zood, vecs[v].znarly == 4, 1'b0);
      end

      // after a win, grade_it is ignored and results hold
      new_game(pat(S_T,S_C,S_O,S_D));
      grade(pat(S_T,S_C,S_O,S_D), 4, 0, 1'b1, 1'b0);
      grade_it = 1'b1;
      step();
      grade_it = 1'b0;
      check("over_not_busy", int'(busy), 0);
      repeat (15) step();
      check("over_round_hold", int'(round_num), 1);
      check("over_won_hold", int'(won), 1);
      check("over_znarly_hold", int'(znarly), 4);

      // eight misses lose the game; a ninth grade is ignored
      new_game(pat(S_T,S_T,S_C,S_C));
      check("new_game_clears_znarly", int'(znarly), 0);
      check("new_game_clears_won", int'(won), 0);
      for (int r = 1; r <= 8; r++)
         grade(pat(S_Z,S_Z,S_Z,S_Z), 0, 0, 1'b0, r == 8);
      grade_it = 1'b1;
      guess    = pat(S_T,S_T,S_C,S_C);
      step();
      grade_it = 1'b0;
      check("ninth_not_busy", int'(busy), 0);
      repeat (15) step();
      check("ninth_round_hold", int'(round_num), 8);
      check("ninth_lost_hold", int'({won, lost}), 1);

      // illegal pegs (0 and 7) pulse bad_guess, then a legal guess grades
      new_game(pat(S_T,S_C,S_O,S_D));
      grade_it = 1'b1;
      guess    = pat(3'd0,S_C,S_O,S_D);
      step();
      grade_it = 1'b0;
      check("bad0_pulse", int'(bad_guess), 1);
      check("bad0_not_busy", int'(busy), 0);
      step();
      check("bad0_pulse_ends", int'(bad_guess), 0);
      check("bad0_round", int'(round_num), 0);
      grade_it = 1'b1;
      guess    = pat(S_T,S_C,3'd7,S_D);
      step();
      grade_it = 1'b0;
      check("bad7_pulse", int'(bad_guess), 1);
      step();
      grade(pat(S_D,S_O,S_C,S_T), 0, 4, 1'b0, 1'b0);

      // start_game three cycles into EXACT aborts the grade and loads a new master
      new_game(pat(S_T,S_C,S_O,S_D));
      grade(pat(S_T,S_T,S_T,S_T), 1, 0, 1'b0, 1'b0);
      grade_it = 1'b1;
      guess    = pat(S_T,S_C,S_O,S_D);
      step();
      grade_it = 1'b0;
      step();
      step();
      new_game(pat(S_Z,S_Z,S_Z,S_Z));
      check("abort_not_busy", int'(busy), 0);
      check("abort_round", int'(round_num), 0);
      check("abort_znarly", int'(znarly), 0);
      repeat (15) step();
      grade(pat(S_Z,S_Z,S_Z,S_Z), 4, 0, 1'b1, 1'b0);

      // reset in the middle of COLOR
      new_game(pat(S_T,S_C,S_O,S_D));
      grade(pat(S_D,S_O,S_C,S_T), 0, 4, 1'b0, 1'b0);
      grade_it = 1'b1;
      guess    = pat(S_T,S_C,S_O,S_D);
      step();
      grade_it = 1'b0;
      repeat (6) step();
      check("color_busy", int'(busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_zood", int'(zood), 0);
      check("mid_rst_round", int'(round_num), 0);
      check("mid_rst_flags", int'({grade_valid, bad_guess, won, lost}), 0);
      grade_it = 1'b1;
      step();
      grade_it = 1'b0;
      check("mid_rst_idle", int'(busy), 0);
      repeat (15) step();
      new_game(pat(S_T,S_C,S_O,S_D));
      grade(pat(S_T,S_C,S_O,S_D), 4, 0, 1'b1, 1'b0);

      step();
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mastermind_grader_ctrl.md
Name: mastermind_grader_ctrl

Overview:
- Round-level controller for the Mastermind game.
- Captures the master pattern on start_game and captures each guess on grade_it.
- Sequences a serial grade: one peg position per cycle for exact matches (Znarly), then one shape per cycle for shape matches (Zood).
- Counts rounds and declares won/lost. Sits between the user-input debouncers and the score/round display logic.

Parameters:
- NUM_POS, 4, pegs per pattern
- NUM_SHAPES, 6, legal shape codes are 1..NUM_SHAPES
- SHAPE_W, 3, bits per peg
- MAX_ROUNDS, 8, guesses allowed per game

Ports:
- clock  in  1  system clock; one clock domain; all state on posedge clock
- reset  in  1  synchronous, active-high; sampled on posedge clock
- start_game  in  1  level; sampled each cycle
- master  in  NUM_POS*SHAPE_W  master pattern; peg 0 in the LSBs
- grade_it  in  1  request to grade `guess`
- guess  in  NUM_POS*SHAPE_W  guess pattern; same packing as master
- busy  out  1  high in EXACT, COLOR and REPORT
- grade_valid  out  1  one-cycle pulse; znarly/zood are new
- znarly  out  $clog2(NUM_POS+1)  exact-position matches
- zood  out  $clog2(NUM_POS+1)  right shape, wrong position
- round_num  out  $clog2(MAX_ROUNDS+1)  guesses graded this game
- bad_guess  out  1  one-cycle pulse; illegal peg in guess
- won  out  1  held until start_game or reset
- lost  out  1  held until start_game or reset

Behaviour:
- Reset:
  - All outputs 0; state IDLE; internal pattern registers 0.
  - Reset mid-grade aborts with no grade_valid.
- States: IDLE, READY, EXACT, COLOR, REPORT, OVER.
- start_game has top priority in every state:
  - Next state READY.
  - Load master into master_q.
  - Clear round_num, won, lost, znarly and zood.
  - Any grade in progress is aborted with no grade_valid.
  - A grade_it in the same cycle is dropped.
- IDLE: wait for start_game; grade_it is ignored.
- READY, on grade_it:
  - If every peg of guess is in 1..NUM_SHAPES: capture guess into guess_q, clear the accumulators, and go to EXACT with idx=0.
  - Otherwise: bad_guess=1 for the next cycle, stay in READY, round_num unchanged.
- EXACT: NUM_POS cycles, idx 0..NUM_POS-1. Add 1 to exact_acc when guess_q[idx]==master_q[idx].
- COLOR: NUM_SHAPES cycles, shape s = 1..NUM_SHAPES. Add min(count of s in guess_q, count of s in master_q) to total_acc.
- REPORT: one cycle.
  - grade_valid=1.
  - Register znarly=exact_acc and zood=total_acc-exact_acc.
  - round_num increments by 1.
  - Next state:
    - OVER with won=1 if exact_acc==NUM_POS.
    - Else OVER with lost=1 if the new round_num==MAX_ROUNDS.
    - Else READY.
  - won and lost are never both 1.
- OVER: hold won/lost/znarly/zood/round_num; grade_it is ignored.
- Latency:
  - grade_it is sampled at edge k.
  - grade_valid is high in the cycle after edge k+NUM_POS+NUM_SHAPES+1, i.e. 11 cycles at defaults.
  - Outputs update at edge k+NUM_POS+NUM_SHAPES+1.
- grade_it while busy is ignored; there is no queuing.
- guess and master may change freely after capture.
- Accumulators do not overflow: both are bounded by NUM_POS, and zood is never negative.
- znarly/zood keep their values until the next REPORT or start_game.

Decomposition:
- mastermind_pkg holds:
  - shape_t enum, SHAPE_W bits: T=1, C=2, O=3, D=4, I=5, Z=6; 0 and 7 are illegal.
  - pattern_t, a packed array of NUM_POS shape_t.
  - grader_state_t for the six states.
  - Constants NUM_POS, NUM_SHAPES, MAX_ROUNDS.
- One sub-module: shape_counter, combinational. It returns the count of shape s in a pattern_t and is instantiated twice (guess_q, master_q).

Test Plan:
- master=T,C,O,D; start_game; guess=T,C,O,D -> grade_valid 11 cycles after grade_it, znarly=4, zood=0, round_num=1, won=1, state OVER.
- master=T,C,O,D; guess=D,O,C,T -> znarly=0, zood=4, round_num=1, won=0, lost=0, back in READY.
- master=T,C,O,D; guess=T,T,T,T -> znarly=1, zood=0 (min-count check); guess=C,T,Z,Z -> znarly=0, zood=2.
- master=T,T,C,C; eight guesses of Z,Z,Z,Z -> round_num counts 1..8, znarly=zood=0 each round, lost=1 after the 8th REPORT; a 9th grade_it is ignored.
- guess=0,C,O,D in READY -> bad_guess pulses once, no busy, round_num unchanged; a following legal guess grades normally.
- start_game asserted 3 cycles into EXACT -> no grade_valid, round_num=0, READY next cycle, new master loaded; reset mid-COLOR -> all outputs 0, IDLE.
